// File: rtl/uart_reg_bridge.sv
// UART command bridge: 'W' addr data writes a register and answers ACK/NAK,
// 'R' addr answers with the register contents; stalled commands time out silently.
module uart_reg_bridge #(
   parameter int NUM_REGS       = 16,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                    clk,
   input  logic                    nrst_in,
   input  logic [7:0]              rx_data_in,
   input  logic                    rx_rdy_in,
   output logic [7:0]              tx_data_out,
   output logic                    tx_rdy_out,
   input  logic                    tx_busy_in,
   input  logic                    tx_done_in,
   output logic [8*NUM_REGS-1:0]   regs_out,
   output logic                    overrun_out
);

   localparam logic [7:0] OP_WRITE = 8'h57;
   localparam logic [7:0] OP_READ  = 8'h52;
   localparam logic [7:0] RSP_ACK  = 8'h06;
   localparam logic [7:0] RSP_NAK  = 8'h15;

   localparam int             CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0]  TC = CW'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      IDLE,
      GET_ADDR,
      GET_DATA,
      SEND,
      WAIT_DONE
   } state_t;

   state_t                     state, state_next;
   logic [NUM_REGS-1:0][7:0]   regs;
   logic [7:0]                 addr_q;
   logic                       op_write_q;
   logic [7:0]                 resp_q, resp_d;
   logic [CW-1:0]              cnt_q;
   logic                       resp_load, op_load, addr_load, wr_en, tx_fire, cnt_clear;
   logic [7:0]                 rd_byte;
   logic                       rx_addr_ok, addr_q_ok, timeout;

   assign rx_addr_ok = ({1'b0, rx_data_in} < 9'(NUM_REGS));
   assign addr_q_ok  = ({1'b0, addr_q} < 9'(NUM_REGS));
   assign timeout    = (cnt_q == TC);
   assign regs_out   = regs;

   // Read mux on the incoming address byte, so the value is sampled the cycle it arrives.
   always_comb begin
      rd_byte = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (rx_data_in == 8'(k)) rd_byte = regs[k];
      end
   end

   always_ff @(posedge clk or negedge nrst_in) begin
      if (!nrst_in) state <= IDLE;
      else          state <= state_next;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_next = state;
      resp_load  = 1'b0;
      resp_d     = resp_q;
      op_load    = 1'b0;
      addr_load  = 1'b0;
      wr_en      = 1'b0;
      tx_fire    = 1'b0;
      cnt_clear  = 1'b1;
      unique case (state)
         IDLE: begin
            if (rx_rdy_in) begin
               if (rx_data_in == OP_WRITE || rx_data_in == OP_READ) begin
                  op_load    = 1'b1;
                  state_next = GET_ADDR;
               end else begin
                  resp_load  = 1'b1;
                  resp_d     = RSP_NAK;
                  state_next = SEND;
               end
            end
         end
         GET_ADDR: begin
            cnt_clear = 1'b0;
            if (rx_rdy_in) begin
               addr_load = 1'b1;
               if (op_write_q) begin
                  state_next = GET_DATA;
               end else begin
                  resp_load  = 1'b1;
                  resp_d     = rx_addr_ok ? rd_byte : RSP_NAK;
                  state_next = SEND;
               end
            end else if (timeout) begin
               state_next = IDLE;
            end
         end
         GET_DATA: begin
            cnt_clear = 1'b0;
            if (rx_rdy_in) begin
               wr_en      = addr_q_ok;
               resp_load  = 1'b1;
               resp_d     = addr_q_ok ? RSP_ACK : RSP_NAK;
               state_next = SEND;
            end else if (timeout) begin
               state_next = IDLE;
            end
         end
         SEND: begin
            if (!tx_busy_in) begin
               tx_fire    = 1'b1;
               state_next = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (tx_done_in) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: the register file is reset too, because its contents are visible on regs_out.
   always_ff @(posedge clk or negedge nrst_in) begin
      if (!nrst_in) begin
         regs <= '0;
      end else begin
         for (int k = 0; k < NUM_REGS; k++) begin
            if (wr_en && addr_q == 8'(k)) regs[k] <= rx_data_in;
         end
      end
   end

   always_ff @(posedge clk or negedge nrst_in) begin
      if (!nrst_in) begin
         addr_q      <= '0;
         op_write_q  <= 1'b0;
         resp_q      <= '0;
         cnt_q       <= '0;
         tx_data_out <= '0;
         tx_rdy_out  <= 1'b0;
         overrun_out <= 1'b0;
      end else begin
         if (op_load)   op_write_q <= (rx_data_in == OP_WRITE);
         if (addr_load) addr_q     <= rx_data_in;
         if (resp_load) resp_q     <= resp_d;
         // An accepted byte restarts the gap count; the count saturates at the terminal value.
         if (cnt_clear || rx_rdy_in) cnt_q <= '0;
         else if (!timeout)          cnt_q <= cnt_q + CW'(1);
         tx_rdy_out <= tx_fire;
         if (tx_fire) tx_data_out <= resp_q;
         if (rx_rdy_in && (state == SEND || state == WAIT_DONE)) overrun_out <= 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Directed bench for uart_reg_bridge: expected responses go into a queue that a
// monitor drains on every tx_rdy_out pulse; a small transmitter model answers tx_done_in.
module tb_uart_reg_bridge;

   localparam int NR = 16;
   localparam int T  = 20;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [7:0]        rx_data = '0;
   logic              rx_rdy = 1'b0;
   logic [7:0]        tx_data_out;
   logic              tx_rdy_out;
   logic              tx_busy;
   logic              tx_done = 1'b0;
   logic [8*NR-1:0]   regs_out;
   logic              overrun_out;

   logic              busy_force = 1'b0;
   logic              model_busy = 1'b0;
   int                done_cnt = 0;
   int                exp_done = 0;
   int                n_pass = 0;
   int                n_total = 0;
   logic [7:0]        exp_q[$];
   logic [NR-1:0][7:0] exp_regs = '0;

   assign tx_busy = busy_force | model_busy;

   uart_reg_bridge #(.NUM_REGS(NR), .TIMEOUT_CYCLES(T)) dut (
      .clk        (clk),
      .nrst_in    (rst_n),
      .rx_data_in (rx_data),
      .rx_rdy_in  (rx_rdy),
      .tx_data_out(tx_data_out),
      .tx_rdy_out (tx_rdy_out),
      .tx_busy_in (tx_busy),
      .tx_done_in (tx_done),
      .regs_out   (regs_out),
      .overrun_out(overrun_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Scoreboard monitor: every cycle with tx_rdy_out high must match the next queued byte.
   always @(negedge clk) begin
      if (rst_n && tx_rdy_out) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL tx_unexpected: got %0h expected no pulse", tx_data_out);
         end else begin
            check("tx_byte", 128'(tx_data_out), 128'(exp_q.pop_front()));
         end
      end
   end

   // Transmitter model: busy for a few cycles after each request, then one done pulse.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && tx_rdy_out) begin
            model_busy = 1'b1;
            repeat (5) @(posedge clk);
            #1;
            tx_done    = 1'b1;
            model_busy = 1'b0;
            @(posedge clk);
            #1;
            tx_done = 1'b0;
            done_cnt++;
         end
      end
   end

   task automatic pulse_rx(input logic [7:0] b);
      rx_data = b;
      rx_rdy  = 1'b1;
      @(posedge clk);
      #1;
      rx_rdy  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_resp(input logic [7:0] b);
      exp_q.push_back(b);
      exp_done++;
   endtask

   task automatic wait_done(input string name);
      int i;
      for (i = 0; i < 300; i++) begin
         if (done_cnt == exp_done) break;
         idle(1);
      end
      check(name, 128'(done_cnt), 128'(exp_done));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      idle(3);
      check("rst_tx_data", 128'(tx_data_out), 128'h00);
      check("rst_tx_rdy",  128'(tx_rdy_out),  128'h0);
      check("rst_overrun", 128'(overrun_out), 128'h0);
      check("rst_regs",    regs_out,          128'h0);
      rst_n = 1'b1;
      idle(2);

      // Write with exact two-cycle response latency.
      pulse_rx(8'h57); pulse_rx(8'h03);
      expect_resp(8'h06);
      pulse_rx(8'hA5);
      exp_regs[3] = 8'hA5;
      check("lat_cycle1", 128'(tx_rdy_out), 128'h0);
      idle(1);
      check("lat_cycle2", 128'(tx_rdy_out), 128'h1);
      wait_done("wr_done");
      check("regs_after_wr", regs_out, exp_regs);

      pulse_rx(8'h52); expect_resp(8'hA5); pulse_rx(8'h03);
      wait_done("rd_done");

      // Bad opcode, out-of-range write and read all answer NAK with no write.
      expect_resp(8'h15); pulse_rx(8'h41);
      wait_done("bad_op_done");
      pulse_rx(8'h57); pulse_rx(8'h10); expect_resp(8'h15); pulse_rx(8'hFF);
      wait_done("oor_wr_done");
      pulse_rx(8'h52); expect_resp(8'h15); pulse_rx(8'h20);
      wait_done("oor_rd_done");
      check("regs_after_nak", regs_out, exp_regs);

      // Silent timeout in GET_DATA, then read back the untouched register.
      pulse_rx(8'h57); pulse_rx(8'h02);
      idle(T + 5);
      check("timeout_no_resp", 128'(done_cnt), 128'(exp_done));
      pulse_rx(8'h52); expect_resp(8'h00); pulse_rx(8'h02);
      wait_done("rd_after_timeout");

      // Data byte on the terminal-count cycle wins over the timeout.
      pulse_rx(8'h57); pulse_rx(8'h02);
      idle(T);
      expect_resp(8'h06); pulse_rx(8'h5C);
      exp_regs[2] = 8'h5C;
      wait_done("tc_byte_done");
      check("regs_after_tc", regs_out, exp_regs);

      // One cycle later the timeout has fired, so the byte is a bad opcode.
      pulse_rx(8'h57); pulse_rx(8'h02);
      idle(T + 1);
      expect_resp(8'h15); pulse_rx(8'h99);
      wait_done("late_byte_done");
      check("regs_after_late", regs_out, exp_regs);

      // Transmitter busy holds the request until it drops.
      busy_force = 1'b1;
      pulse_rx(8'h52); expect_resp(8'hA5); pulse_rx(8'h03);
      idle(50);
      check("busy_hold", 128'(tx_rdy_out), 128'h0);
      busy_force = 1'b0;
      idle(1);
      check("busy_release", 128'(tx_rdy_out), 128'h1);
      wait_done("busy_done");

      // A byte during WAIT_DONE is dropped and flags overrun.
      check("overrun_clear", 128'(overrun_out), 128'h0);
      pulse_rx(8'h57); pulse_rx(8'h04); expect_resp(8'h06); pulse_rx(8'hC3);
      exp_regs[4] = 8'hC3;
      idle(2);
      pulse_rx(8'h41);
      check("overrun_set", 128'(overrun_out), 128'h1);
      wait_done("overrun_done");
      check("regs_after_ovr", regs_out, exp_regs);

      // Reset during WAIT_DONE clears everything; the next command works normally.
      pulse_rx(8'h57); pulse_rx(8'h05); expect_resp(8'h06); pulse_rx(8'h33);
      idle(2);
      rst_n = 1'b0;
      #1;
      exp_regs = '0;
      check("mid_rst_tx_data", 128'(tx_data_out), 128'h00);
      check("mid_rst_tx_rdy",  128'(tx_rdy_out),  128'h0);
      check("mid_rst_overrun", 128'(overrun_out), 128'h0);
      check("mid_rst_regs",    regs_out,          exp_regs);
      idle(12);
      rst_n = 1'b1;
      wait_done("aborted_done");
      idle(3);
      pulse_rx(8'h57); pulse_rx(8'h01); expect_resp(8'h06); pulse_rx(8'h77);
      exp_regs[1] = 8'h77;
      wait_done("post_rst_wr");
      check("regs_post_rst", regs_out, exp_regs);
      pulse_rx(8'h52); expect_resp(8'h00); pulse_rx(8'h03);
      wait_done("post_rst_rd");

      idle(5);
      check("queue_empty", 128'(exp_q.size()), 128'h0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/uart_reg_bridge.md
UART_REG_BRIDGE -- requirements
Module: uart_reg_bridge

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16: number of 8-bit registers, range 2..256.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000: maximum clk cycles allowed between bytes of one command.
REQ-003 SHALL have port clk  input  1  single system clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port nrst_in  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port rx_data_in  input  8  received byte from the UART receiver.
REQ-006 SHALL have port rx_rdy_in  input  1  one-cycle pulse; rx_data_in is valid in the same cycle.
REQ-007 SHALL have port tx_data_out  output  8  byte to be sent by the UART transmitter.
REQ-008 SHALL have port tx_rdy_out  output  1  one-cycle pulse requesting transmission of tx_data_out.
REQ-009 SHALL have port tx_busy_in  input  1  transmitter is busy.
REQ-010 SHALL have port tx_done_in  input  1  one-cycle pulse: transmitter has finished the byte.
REQ-011 SHALL have port regs_out  output  8*NUM_REGS  register file, flattened; register k occupies bits [8k+7:8k].
REQ-012 SHALL have port overrun_out  output  1  sticky flag: a byte was dropped while a response was pending.

Function
REQ-013 SHALL implement an FSM with states IDLE, GET_ADDR, GET_DATA, SEND, WAIT_DONE.
REQ-014 In IDLE, on rx_rdy_in with byte 0x57 ('W') or 0x52 ('R'), SHALL latch the opcode and go to GET_ADDR.
REQ-015 In IDLE, on any other byte, SHALL load response 0x15 (NAK) and go to SEND.
REQ-016 In GET_ADDR, on rx_rdy_in, SHALL latch the address; for 'W' it SHALL go to GET_DATA; for 'R' it SHALL load response regs[addr] and go to SEND.
REQ-017 In GET_DATA, on rx_rdy_in with address < NUM_REGS, SHALL write the byte to regs[addr] on that clock edge, load response 0x06 (ACK) and go to SEND.
REQ-018 Any address >= NUM_REGS SHALL produce response 0x15 (NAK) with no register write; a 'W' still consumes its data byte before the NAK is sent.
REQ-019 Read data SHALL be the register value sampled on the cycle the address byte is accepted.
REQ-020 In SEND, SHALL drive tx_data_out = response and pulse tx_rdy_out for exactly one cycle, on the first cycle tx_busy_in is low, then go to WAIT_DONE.
REQ-021 In WAIT_DONE, on tx_done_in, SHALL return to IDLE; tx_data_out SHALL hold the response until then.
REQ-022 Minimum latency: tx_rdy_out SHALL be asserted 2 cycles after the rx_rdy_in of the final command byte, given tx_busy_in is low.
REQ-023 rx_rdy_in in SEND or WAIT_DONE SHALL be ignored and SHALL set overrun_out; overrun_out SHALL be cleared only by reset.
REQ-024 An inter-byte counter SHALL reset on each accepted byte in GET_ADDR/GET_DATA and increment otherwise; on reaching TIMEOUT_CYCLES it SHALL return to IDLE silently, with no response and no write.
REQ-025 If rx_rdy_in coincides with the timeout terminal count, the byte SHALL take priority and the timeout SHALL NOT fire.
REQ-026 The counter width SHALL be $clog2(TIMEOUT_CYCLES+1); the counter SHALL saturate and SHALL NOT wrap.

Reset
REQ-027 Asserting nrst_in SHALL, asynchronously: set the FSM to IDLE, set all regs to 0x00, set tx_data_out=0x00, tx_rdy_out=0, overrun_out=0, and clear the counter, opcode and address.
REQ-028 Reset in any state mid-command or mid-response SHALL abort it with no write and no further tx_rdy_out pulse after release.
REQ-029 After deassertion, the first rx_rdy_in SHALL be treated as an opcode byte.

Verification
REQ-030 Write 0x57,0x03,0xA5 -> regs[3]=0xA5, one tx_rdy_out with 0x06, others unchanged.
REQ-031 Read 0x52,0x03 after REQ-030 -> tx_data_out=0xA5 with one tx_rdy_out; after reset, read returns 0x00.
REQ-032 Bytes 0x41; 0x57,0x10,0xFF (NUM_REGS=16) -> NAK 0x15 each; regs_out unchanged.
REQ-033 0x57,0x02 then silence for TIMEOUT_CYCLES -> no tx_rdy_out; next 0x52,0x02 returns 0x00; with a byte arriving at the terminal-count cycle -> command completes.
REQ-034 tx_busy_in held high 50 cycles during SEND -> tx_rdy_out delayed until busy low; rx_rdy_in during WAIT_DONE -> overrun_out=1, byte ignored.
REQ-035 nrst_in low during WAIT_DONE -> all outputs at reset values, FSM in IDLE, following write command works normally.
